// File: rtl/scan_pkg.sv
// Shared types and constants for the digit scan path.
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } scan_state_t;

  localparam int SCAN_DIGITS = 8;
  localparam int SCAN_IDX_W  = 3;

  // Decoder enable pattern {g1,g2,g3}
  localparam logic [2:0] DEC_EN_ON  = 3'b100;
  localparam logic [2:0] DEC_EN_OFF = 3'b000;

endpackage

// File: rtl/scan_next_idx.sv
// Circular priority search: first set mask bit strictly after cur,
// wrapping 7->0, with cur itself considered last.
module scan_next_idx
  import scan_pkg::*;
(
  input  logic [SCAN_DIGITS-1:0] mask,
  input  logic [SCAN_IDX_W-1:0]  cur,
  output logic [SCAN_IDX_W-1:0]  nxt,
  output logic                   found,
  output logic                   wrap
);

  logic [SCAN_IDX_W-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    nxt   = cur;
    found = 1'b0;
    idx   = '0;
    for (int i = SCAN_DIGITS; i >= 1; i--) begin
      idx = cur + SCAN_IDX_W'(i);
      if (mask[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
    wrap = found && (nxt <= cur);
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed 8-digit scan controller driving a 3-to-8 decoder.
// Define DIGIT_SCAN_BLANK_EN to insert BLANK_CYC blanked clocks between digits.
module digit_scan_ctrl
  import scan_pkg::*;
#(
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_mask,
  input  logic [31:0] digit_data,
  output logic [2:0]  sel,
  output logic        g1,
  output logic        g2,
  output logic        g3,
  output logic [3:0]  nib,
  output logic        frame_done
);

  localparam int CMAX = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  scan_state_t           state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [SCAN_IDX_W-1:0] sel_n;
  logic [2:0]            dec_en, dec_en_n;
  logic                  fd_n;

  logic [SCAN_IDX_W-1:0] srch_cur, srch_nxt;
  logic                  srch_found, srch_wrap;

  // From IDLE, starting the search at 7 yields the lowest set bit.
  assign srch_cur = (state == IDLE) ? SCAN_IDX_W'(SCAN_DIGITS - 1) : sel;

  scan_next_idx u_next (
    .mask  (en_mask),
    .cur   (srch_cur),
    .nxt   (srch_nxt),
    .found (srch_found),
    .wrap  (srch_wrap)
  );

  assign g1 = dec_en[2];
  assign g2 = dec_en[1];
  assign g3 = dec_en[0];

  // State, counter and registered outputs; reset dominates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      sel        <= '0;
      dec_en     <= DEC_EN_OFF;
      nib        <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      sel        <= sel_n;
      dec_en     <= dec_en_n;
      nib        <= digit_data[sel*4 +: 4];
      frame_done <= fd_n;
    end
  end

  // Next-state: digit dwell, optional blanking, and advance to next enabled digit.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    sel_n    = sel;
    dec_en_n = dec_en;
    fd_n     = 1'b0;
    case (state)
      IDLE: begin
        dec_en_n = DEC_EN_OFF;
        if (srch_found) begin
          sel_n    = srch_nxt;
          dec_en_n = DEC_EN_ON;
          cnt_n    = '0;
          state_n  = SHOW;
        end
      end
      SHOW: begin
        if (cnt == CW'(DIV - 1)) begin
`ifdef DIGIT_SCAN_BLANK_EN
          state_n  = BLANK;
          dec_en_n = DEC_EN_OFF;
          cnt_n    = '0;
`else
          cnt_n = '0;
          if (srch_found) begin
            sel_n    = srch_nxt;
            dec_en_n = DEC_EN_ON;
            fd_n     = srch_wrap;
          end else begin
            dec_en_n = DEC_EN_OFF;
            state_n  = IDLE;
          end
`endif
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
`ifdef DIGIT_SCAN_BLANK_EN
      BLANK: begin
        if (cnt == CW'(BLANK_CYC - 1)) begin
          cnt_n = '0;
          if (srch_found) begin
            sel_n    = srch_nxt;
            dec_en_n = DEC_EN_ON;
            fd_n     = srch_wrap;
            state_n  = SHOW;
          end else begin
            dec_en_n = DEC_EN_OFF;
            state_n  = IDLE;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
`endif
      default: begin
        state_n  = IDLE;
        dec_en_n = DEC_EN_OFF;
        cnt_n    = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Self-checking bench for digit_scan_ctrl against a timeline reference model.
module tb_digit_scan_ctrl;

  localparam int DIV       = 4;
  localparam int BLANK_CYC = 2;
`ifdef DIGIT_SCAN_BLANK_EN
  localparam int PERIOD = DIV + BLANK_CYC;
`else
  localparam int PERIOD = DIV;
`endif
  localparam int FRAME = 8 * PERIOD;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  en_mask;
  logic [31:0] digit_data;
  logic [2:0]  sel;
  logic        g1, g2, g3;
  logic [3:0]  nib;
  logic        frame_done;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: one age counter across a whole digit period.
  bit       m_act;
  int       m_sel;
  int       m_age;
  logic [3:0] e_nib;
  bit       e_fd;
  bit       e_g1;

  digit_scan_ctrl #(.DIV(DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .en_mask(en_mask), .digit_data(digit_data),
    .sel(sel), .g1(g1), .g2(g2), .g3(g3), .nib(nib), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Advance model for the coming edge, then clock the DUT and settle.
  task automatic tick();
    int nsel;
    bit hit;
    if (!rst_n) begin
      m_act = 0; m_sel = 0; m_age = 0; e_nib = 4'h0; e_fd = 0;
    end else begin
      e_nib = 4'((digit_data >> (4 * m_sel)) & 32'hF);
      e_fd  = 0;
      if (!m_act) begin
        if (en_mask != 8'h00) begin
          for (int k = 7; k >= 0; k--) if (en_mask[k]) m_sel = k;
          m_act = 1; m_age = 0;
        end
      end else if (m_age == PERIOD - 1) begin
        hit = 0; nsel = 0;
        for (int k = 8; k >= 1; k--)
          if (en_mask[(m_sel + k) % 8]) begin nsel = (m_sel + k) % 8; hit = 1; end
        if (hit) begin
          e_fd = (nsel <= m_sel); m_sel = nsel; m_age = 0;
        end else begin
          m_act = 0; m_age = 0;
        end
      end else begin
        m_age++;
      end
    end
    e_g1 = m_act && (m_age < DIV);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en_mask = 8'hFF; digit_data = 32'h76543210;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if ({sel, g1, g2, g3, nib, frame_done} !== 11'h0) begin
        n_err++;
        $display("FAIL reset c%0d: sel=%0d g1=%b g2=%b g3=%b nib=%h fd=%b, want all 0",
                 c, sel, g1, g2, g3, nib, frame_done);
      end
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (g1 !== 1'b1 || sel !== 3'd0) begin
      n_err++;
      $display("FAIL reset_release: g1=%b sel=%0d, want g1=1 sel=0", g1, sel);
    end
  endtask

  task automatic test_full_mask();
    int pulses = 0, last = -1;
    rst_n = 1'b0; en_mask = 8'hFF; digit_data = 32'h76543210;
    tick();
    rst_n = 1'b1;
    for (int c = 1; c <= 3 * FRAME; c++) begin
      tick();
      n_cmp++;
      if ({sel, g1, g2, g3, nib, frame_done} !== {3'(m_sel), e_g1, 2'b00, e_nib, e_fd}) begin
        n_err++;
        $display("FAIL full_mask c%0d: sel=%0d g1=%b g2=%b g3=%b nib=%h fd=%b, want sel=%0d g1=%b nib=%h fd=%b",
                 c, sel, g1, g2, g3, nib, frame_done, m_sel, e_g1, e_nib, e_fd);
      end
      if (frame_done === 1'b1) begin
        if (sel !== 3'd0) begin
          n_err++;
          $display("FAIL frame_wrap_sel: sel=%0d at pulse, want 0", sel);
        end
        if (last >= 0 && c - last != FRAME) begin
          n_err++;
          $display("FAIL frame_period: %0d clocks, want %0d", c - last, FRAME);
        end
        last = c; pulses++;
      end
    end
    n_cmp++;
    if (pulses != 2) begin
      n_err++;
      $display("FAIL frame_count: %0d pulses, want 2", pulses);
    end
  endtask

  task automatic test_sparse();
    logic [7:0] masks [2] = '{8'b1000_0100, 8'h10};
    for (int m = 0; m < 2; m++) begin
      int pulses = 0;
      rst_n = 1'b0; en_mask = masks[m]; digit_data = $urandom;
      tick();
      rst_n = 1'b1;
      for (int c = 1; c <= 4 * PERIOD; c++) begin
        tick();
        n_cmp++;
        if ({sel, g1, g2, g3, nib, frame_done} !== {3'(m_sel), e_g1, 2'b00, e_nib, e_fd}) begin
          n_err++;
          $display("FAIL sparse m%0d c%0d: sel=%0d g1=%b nib=%h fd=%b, want sel=%0d g1=%b nib=%h fd=%b",
                   m, c, sel, g1, nib, frame_done, m_sel, e_g1, e_nib, e_fd);
        end
        if (frame_done === 1'b1) pulses++;
      end
      // 4 periods from first show: mask {2,7} wraps once (7->2), mask {4} wraps every period
      n_cmp++;
      if (pulses != ((m == 0) ? 1 : 3)) begin
        n_err++;
        $display("FAIL sparse_pulses m%0d: %0d, want %0d", m, pulses, (m == 0) ? 1 : 3);
      end
    end
  endtask

  task automatic test_mask_clear();
    int shown3 = 0;
    int guard = 0;
    rst_n = 1'b0; en_mask = 8'hFF; digit_data = 32'hFEDCBA98;
    tick();
    rst_n = 1'b1;
    while (!(m_sel == 3 && m_age == 1) && guard < 200) begin
      tick(); guard++;
      if (sel === 3'd3 && g1 === 1'b1) shown3++;
    end
    n_cmp++;
    if (guard >= 200) begin
      n_err++;
      $display("FAIL mask_clear_wait: timeout, sel=%0d", sel);
    end
    en_mask = 8'h00;
    for (int c = 0; c < PERIOD + 2; c++) begin
      tick();
      if (sel === 3'd3 && g1 === 1'b1) shown3++;
      n_cmp++;
      if ({sel, g1, g2, g3, nib, frame_done} !== {3'(m_sel), e_g1, 2'b00, e_nib, e_fd}) begin
        n_err++;
        $display("FAIL mask_clear c%0d: sel=%0d g1=%b nib=%h fd=%b, want sel=%0d g1=%b nib=%h fd=%b",
                 c, sel, g1, nib, frame_done, m_sel, e_g1, e_nib, e_fd);
      end
    end
    n_cmp++;
    if (shown3 != DIV || g1 !== 1'b0 || sel !== 3'd3) begin
      n_err++;
      $display("FAIL mask_clear_end: digit3 shown %0d g1=%b sel=%0d, want %0d 0 3", shown3, g1, sel, DIV);
    end
    en_mask = 8'h01;
    tick();
    n_cmp++;
    if (sel !== 3'd0 || g1 !== 1'b1) begin
      n_err++;
      $display("FAIL idle_exit: sel=%0d g1=%b, want 0 1", sel, g1);
    end
  endtask

  task automatic test_reset_mid();
    // phase 0: reset mid-SHOW; phase 1: mid-BLANK (only if blanking is built)
    for (int p = 0; p < 2; p++) begin
      int guard = 0;
      int tgt_age = (p == 0) ? 2 : DIV;
      if (p == 1 && PERIOD == DIV) continue;
      rst_n = 1'b1; en_mask = 8'hFF; digit_data = $urandom;
      while (!(m_act && m_sel == 5 && m_age == tgt_age) && guard < 200) begin
        tick(); guard++;
      end
      rst_n = 1'b0;
      tick();
      n_cmp++;
      if (guard >= 200 || {sel, g1, g2, g3, nib, frame_done} !== 11'h0) begin
        n_err++;
        $display("FAIL reset_mid p%0d: sel=%0d g1=%b nib=%h fd=%b guard=%0d, want all 0",
                 p, sel, g1, nib, frame_done, guard);
      end
      rst_n = 1'b1; en_mask = 8'b0110_1000;
      tick();
      n_cmp++;
      if (sel !== 3'd3 || g1 !== 1'b1 || frame_done !== 1'b0) begin
        n_err++;
        $display("FAIL restart p%0d: sel=%0d g1=%b fd=%b, want 3 1 0", p, sel, g1, frame_done);
      end
    end
  endtask

  task automatic test_random();
    rst_n = 1'b0; en_mask = 8'h00; digit_data = 32'h0;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 15) == 0) en_mask = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 3) == 0) digit_data = $urandom;
      if ($urandom_range(0, 199) == 0) rst_n = 1'b0; else rst_n = 1'b1;
      tick();
      n_cmp++;
      if ({sel, g1, g2, g3, nib, frame_done} !== {3'(m_sel), e_g1, 2'b00, e_nib, e_fd}) begin
        n_err++;
        $display("FAIL random c%0d: mask=%h sel=%0d g1=%b g2=%b g3=%b nib=%h fd=%b, want sel=%0d g1=%b nib=%h fd=%b",
                 c, en_mask, sel, g1, g2, g3, nib, frame_done, m_sel, e_g1, e_nib, e_fd);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; en_mask = 8'h00; digit_data = 32'h0;
    m_act = 0; m_sel = 0; m_age = 0; e_nib = 4'h0; e_fd = 0; e_g1 = 0;
    #1;
    test_reset();
    test_full_mask();
    test_sparse();
    test_mask_clear();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/digit_scan_ctrl.md
# digit_scan_ctrl

Time-multiplexed scan controller that drives the 3-to-8 decoder stage of the 8-digit display path. Cycles a 3-bit digit index through the enabled digits, holding each for a programmable number of clocks, and generates the decoder enable pattern (`g1`/`g2`/`g3` = 1/0/0 active, 0/0/0 blanked). Also selects the matching 4-bit data nibble for the segment path and flags frame completion.

## Interface
- `DIV`, 50000: clocks each digit is shown; must be ≥ 2.
- `BLANK_CYC`, 4: clocks of blanking between digits when blanking is compiled in; must be ≥ 1.
- `clk` input 1: single system clock; all logic on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `en_mask` input 8: bit i = 1 includes digit i in the scan.
- `digit_data` input 32: nibble i is `digit_data[4*i+3:4*i]`.
- `sel` output 3: digit index to the decoder `A` input.
- `g1` output 1: decoder enable; 1 while showing, 0 while idle or blanked.
- `g2` output 1: always 0.
- `g3` output 1: always 0.
- `nib` output 4: data nibble for the digit currently in `sel`.
- `frame_done` output 1: one-cycle pulse when the scan wraps.

## Operation
- All outputs registered. Reset values: `sel`=0, `g1`=0, `g2`=0, `g3`=0, `nib`=0, `frame_done`=0, state IDLE, counter 0.
- States: IDLE, SHOW, BLANK (BLANK exists only with the macro).
- IDLE: `g1`=0. If `en_mask`≠0, the next edge loads `sel` = lowest set bit, `g1`=1, counter 0, and enters SHOW.
- SHOW: counter increments each clock. At counter = DIV−1 the digit ends:
  - With blanking: go to BLANK, `g1`=0, counter 0, `sel` unchanged.
  - Without blanking: advance directly.
- BLANK: counter increments. At counter = BLANK_CYC−1, advance.
- Advance: circular search of `en_mask`, sampled at that edge, from `sel`+1 upward, wrapping 7→0, including `sel` itself last.
  - Found: load `sel`, `g1`=1, counter 0, enter SHOW.
  - None found: IDLE, `g1`=0, `sel` unchanged.
- `frame_done`=1 for exactly the advance cycle where the new index ≤ the old index. This includes the single-enabled-digit case, where every advance wraps.
- `en_mask` is only evaluated at IDLE exit and at advance. Clearing the current digit's bit mid-SHOW does not cut the digit short.
- `nib` <= `digit_data` nibble at `sel` every clock, in all states. Data changes are visible one clock later without waiting for a digit boundary.
- Counter width is `$clog2(max(DIV, BLANK_CYC))`. It never exceeds its terminal value and has no overflow path.

## Timing
- Reset release to first `g1`=1: one clock if `en_mask`≠0.
- Digit period: DIV clocks, or DIV+BLANK_CYC with blanking.
- Full-mask frame: 8·DIV clocks, or 8·(DIV+BLANK_CYC) with blanking.
- `sel` and `g1` change on the same edge. `nib` lags a `sel` change by one clock.
- `rst_n` low at any edge, including mid-SHOW or mid-BLANK, forces reset values at that edge. Reset dominates all other events.

## Configuration
- `DIGIT_SCAN_BLANK_EN` defined: BLANK state compiled in. `g1` drops for BLANK_CYC clocks between digits to suppress ghosting.
- Not defined: no BLANK state and no `BLANK_CYC` logic. SHOW advances straight to the next digit, and `g1` stays 1 across digit changes.

## Structure
- Shared package `scan_pkg`:
  - State enum `scan_state_t` {IDLE, SHOW, BLANK}.
  - Constant `SCAN_DIGITS`=8.
  - Constant `SCAN_IDX_W`=3.
  - Constant `DEC_EN_ON`=3'b100 (decoder enable pattern, active).
  - Constant `DEC_EN_OFF`=3'b000 (decoder enable pattern, blanked).
- One sub-module: `scan_next_idx`, a combinational circular priority search. Inputs: mask and current index. Outputs: next index, found flag, wrap flag.

## Test plan
- Reset: `rst_n`=0 for 3 clocks, mask 8'hFF → `sel`=0, `g1`/`g2`/`g3`=0, `nib`=0, `frame_done`=0 throughout; first `g1`=1 one clock after release.
- DIV=4, no macro, mask 8'hFF, `digit_data`=32'h76543210 → `sel` 0..7, each held 4 clocks; `nib` equals `sel` one clock late; `frame_done` pulses once per 32 clocks, on the 7→0 edge.
- DIV=4, BLANK_CYC=2, macro on → pattern repeats per digit: 4 clocks `g1`=1, then 2 clocks `g1`=0 with `sel` held; frame period 48 clocks.
- Mask 8'b1000_0100 → `sel` alternates 2,7,2,7; `frame_done` only on 7→2. Mask 8'h10 → `sel` stays 4 and `frame_done` pulses every digit period.
- Mask cleared to 0 at `sel`=3 mid-SHOW → digit 3 completes its full DIV clocks, then IDLE with `g1`=0. Mask set to 8'h01 → next clock `sel`=0, `g1`=1.
- `rst_n`=0 asserted mid-BLANK and mid-SHOW → every output at its reset value on that edge; scan restarts from the lowest enabled digit.
